// File: rtl/spi_slave_interface.sv
// rtl/spi_slave_interface.sv - SPI mode-3 slave, byte-oriented, oversampled by the system clock
// sclk/slave_select/mosi are synchronized; all framing runs on the synchronized copies.
module spi_slave_interface #(
   parameter int SYNC_STAGES = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       sclk,
   input  logic       slave_select,
   input  logic       mosi,
   output logic       miso,
   output logic       miso_en,
   input  logic [7:0] send_data,
   output logic       send_load,
   output logic [7:0] recieved_data,
   output logic       end_transmission,
   output logic       frame_error
);

   localparam logic [0:0] ST_IDLE  = 1'b0;
   localparam logic [0:0] ST_SHIFT = 1'b1;

   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
   logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
   logic [SYNC_STAGES-1:0] sync_valid_q, sync_valid_d;
   logic                   sclk_prev_q, sclk_prev_d;
   logic                   armed_q, armed_d;
   logic [0:0]             state_q, state_d;
   logic [7:0]             tx_q, tx_d;
   logic [7:0]             rx_q, rx_d;
   logic [3:0]             bit_cnt_q, bit_cnt_d;
   logic                   miso_q, miso_d;
   logic                   miso_en_q, miso_en_d;
   logic [7:0]             recieved_data_q, recieved_data_d;
   logic                   end_transmission_q, end_transmission_d;
   logic                   send_load_q, send_load_d;
   logic                   frame_error_q, frame_error_d;

   logic sclk_s, ss_s, mosi_s, sclk_rise, sclk_fall;

   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign ss_s      = ss_sync_q[SYNC_STAGES-1];
   assign mosi_s    = mosi_sync_q[SYNC_STAGES-1];
   assign sclk_rise = ~sclk_prev_q & sclk_s;
   assign sclk_fall = sclk_prev_q & ~sclk_s;

   always_comb begin
      sclk_sync_d  = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
      ss_sync_d    = {ss_sync_q[SYNC_STAGES-2:0], slave_select};
      mosi_sync_d  = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
      sync_valid_d = {sync_valid_q[SYNC_STAGES-2:0], 1'b1};
      sclk_prev_d  = sclk_s;
      // Only arm once a real (post-reset) deselect has flushed through the synchronizer,
      // so a master still holding slave_select low after a reset cannot start a frame.
      armed_d      = armed_q | (sync_valid_q[SYNC_STAGES-1] & ss_s);
   end

   always_comb begin
      state_d            = state_q;
      tx_d               = tx_q;
      rx_d               = rx_q;
      bit_cnt_d          = bit_cnt_q;
      miso_d             = miso_q;
      miso_en_d          = miso_en_q;
      recieved_data_d    = recieved_data_q;
      end_transmission_d = 1'b0;
      send_load_d        = 1'b0;
      frame_error_d      = 1'b0;

      case (state_q)
         ST_IDLE: begin
            miso_d    = 1'b1;
            miso_en_d = 1'b0;
            bit_cnt_d = 4'd0;
            if (armed_q && !ss_s) begin
               state_d     = ST_SHIFT;
               tx_d        = send_data;
               rx_d        = 8'h00;
               miso_d      = send_data[7];
               miso_en_d   = 1'b1;
               send_load_d = 1'b1;
            end
         end
         default: begin
            if (ss_s) begin
               // Deselect wins over a coincident 8th rise: the partial byte is dropped.
               state_d       = ST_IDLE;
               miso_d        = 1'b1;
               miso_en_d     = 1'b0;
               bit_cnt_d     = 4'd0;
               rx_d          = 8'h00;
               frame_error_d = (bit_cnt_q != 4'd0);
            end else if (sclk_fall) begin
               miso_d = tx_q[7];
            end else if (sclk_rise) begin
               if (bit_cnt_q == 4'd7) begin
                  recieved_data_d    = {rx_q[6:0], mosi_s};
                  end_transmission_d = 1'b1;
                  bit_cnt_d          = 4'd0;
                  rx_d               = 8'h00;
                  tx_d               = send_data;
                  send_load_d        = 1'b1;
               end else begin
                  tx_d      = {tx_q[6:0], 1'b0};
                  rx_d      = {rx_q[6:0], mosi_s};
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sclk_sync_q        <= '1;
         ss_sync_q          <= '1;
         mosi_sync_q        <= '0;
         sync_valid_q       <= '0;
         sclk_prev_q        <= 1'b1;
         armed_q            <= 1'b0;
         state_q            <= ST_IDLE;
         tx_q               <= 8'h00;
         rx_q               <= 8'h00;
         bit_cnt_q          <= 4'd0;
         miso_q             <= 1'b1;
         miso_en_q          <= 1'b0;
         recieved_data_q    <= 8'h00;
         end_transmission_q <= 1'b0;
         send_load_q        <= 1'b0;
         frame_error_q      <= 1'b0;
      end else begin
         sclk_sync_q        <= sclk_sync_d;
         ss_sync_q          <= ss_sync_d;
         mosi_sync_q        <= mosi_sync_d;
         sync_valid_q       <= sync_valid_d;
         sclk_prev_q        <= sclk_prev_d;
         armed_q            <= armed_d;
         state_q            <= state_d;
         tx_q               <= tx_d;
         rx_q               <= rx_d;
         bit_cnt_q          <= bit_cnt_d;
         miso_q             <= miso_d;
         miso_en_q          <= miso_en_d;
         recieved_data_q    <= recieved_data_d;
         end_transmission_q <= end_transmission_d;
         send_load_q        <= send_load_d;
         frame_error_q      <= frame_error_d;
      end
   end

   assign miso             = miso_q;
   assign miso_en          = miso_en_q;
   assign recieved_data    = recieved_data_q;
   assign end_transmission = end_transmission_q;
   assign send_load        = send_load_q;
   assign frame_error      = frame_error_q;

endmodule
